// File: rtl/floating_point_adder.sv
// IEEE-754 binary adder/subtractor with round-to-nearest-even and exception flags.
// The result is computed combinationally and registered on the rising clock edge.
// Ports:
//   clk, rst_n             - clock and asynchronous active-low reset
//   a, b                   - operands {sign, exponent, fraction}
//   subtract               - 1: compute a - b
//   out                    - registered result
//   underflow_flag         - registered; result is subnormal
//   overflow_flag          - registered; result is infinity
//   invalid_operation_flag - registered; result is NaN
module floating_point_adder #(
  parameter int unsigned ExponentWidth = 8,
  parameter int unsigned MantissaWidth = 23
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ExponentWidth+MantissaWidth:0]   a,
  input  logic [ExponentWidth+MantissaWidth:0]   b,
  input  logic                                   subtract,
  output logic [ExponentWidth+MantissaWidth:0]   out,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag
);

  localparam int unsigned W   = ExponentWidth + MantissaWidth + 1;
  localparam int unsigned SW  = MantissaWidth + 1;   // significand with hidden bit
  localparam int unsigned XW  = MantissaWidth + 4;   // significand plus guard/round/sticky
  localparam int unsigned EXW = ExponentWidth + 2;   // exponent with headroom
  localparam int unsigned MTW = MantissaWidth + 2;   // rounded significand with carry
  localparam logic [ExponentWidth-1:0] ExpOnes = '1;

  // Operand fields and classification
  logic                     w_sa, w_sb;
  logic [ExponentWidth-1:0] w_ea, w_eb;
  logic [MantissaWidth-1:0] w_fa, w_fb;
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic w_a_ge;

  assign w_sa = a[W-1];
  assign w_sb = b[W-1] ^ subtract;
  assign w_ea = a[W-2:MantissaWidth];
  assign w_eb = b[W-2:MantissaWidth];
  assign w_fa = a[MantissaWidth-1:0];
  assign w_fb = b[MantissaWidth-1:0];

  assign w_a_zero = (w_ea == '0) && (w_fa == '0);
  assign w_b_zero = (w_eb == '0) && (w_fb == '0);
  assign w_a_inf  = (w_ea == ExpOnes) && (w_fa == '0);
  assign w_b_inf  = (w_eb == ExpOnes) && (w_fb == '0);
  assign w_a_nan  = (w_ea == ExpOnes) && (w_fa != '0);
  assign w_b_nan  = (w_eb == ExpOnes) && (w_fb != '0);

  // The raw exponent:fraction encoding is monotonic in magnitude
  assign w_a_ge = a[W-2:0] >= b[W-2:0];

  // Finite-path datapath
  logic                 w_sl, w_ss;
  logic [EXW-1:0]       w_el, w_es, w_ediff, w_exp, w_lz, w_sh;
  logic [SW-1:0]        w_sigl, w_sigs;
  logic [XW-1:0]        w_big, w_small, w_m;
  logic [2*XW-1:0]      w_wide;
  logic [XW:0]          w_sum;
  logic [MTW-1:0]       w_mant;
  logic                 w_rup;
  logic [ExponentWidth-1:0] w_eenc;
  logic [W-1:0]         w_fin_res;
  logic                 w_fin_ovf, w_fin_unf;

  always_comb begin
    w_sl = 1'b0; w_ss = 1'b0;
    w_el = '0; w_es = '0; w_sigl = '0; w_sigs = '0;
    w_ediff = '0; w_exp = '0; w_lz = '0; w_sh = '0;
    w_big = '0; w_small = '0; w_m = '0; w_wide = '0; w_sum = '0;
    w_mant = '0; w_rup = 1'b0; w_eenc = '0;
    w_fin_res = '0; w_fin_ovf = 1'b0; w_fin_unf = 1'b0;

    // Order by magnitude; subnormals take exponent 1 with a hidden 0
    if (w_a_ge) begin
      w_sl = w_sa; w_ss = w_sb;
      w_el = (w_ea == '0) ? EXW'(1) : EXW'(w_ea);
      w_es = (w_eb == '0) ? EXW'(1) : EXW'(w_eb);
      w_sigl = {(w_ea != '0), w_fa};
      w_sigs = {(w_eb != '0), w_fb};
    end else begin
      w_sl = w_sb; w_ss = w_sa;
      w_el = (w_eb == '0) ? EXW'(1) : EXW'(w_eb);
      w_es = (w_ea == '0) ? EXW'(1) : EXW'(w_ea);
      w_sigl = {(w_eb != '0), w_fb};
      w_sigs = {(w_ea != '0), w_fa};
    end

    // Align the smaller operand, folding shifted-out bits into sticky
    w_ediff = w_el - w_es;
    w_big   = {w_sigl, 3'b000};
    if (w_ediff >= EXW'(MantissaWidth + 3)) begin
      w_small = {{(XW-1){1'b0}}, |w_sigs};
    end else begin
      w_wide  = {w_sigs, 3'b000, {XW{1'b0}}} >> w_ediff;
      w_small = w_wide[2*XW-1:XW] | {{(XW-1){1'b0}}, |w_wide[XW-1:0]};
    end

    w_exp = w_el;
    if (w_sl == w_ss) begin
      w_sum = {1'b0, w_big} + {1'b0, w_small};
      if (w_sum[XW]) begin
        w_m   = w_sum[XW:1] | {{(XW-1){1'b0}}, w_sum[0]};
        w_exp = w_el + EXW'(1);
      end else begin
        w_m = w_sum[XW-1:0];
      end
    end else begin
      w_m  = w_big - w_small;
      w_lz = EXW'(XW);
      for (int i = 0; i < int'(XW); i++) begin
        if (w_m[i]) w_lz = EXW'(int'(XW) - 1 - i);
      end
      // Never normalize below exponent 1; what remains encodes as subnormal
      w_sh  = (w_lz < (w_el - EXW'(1))) ? w_lz : (w_el - EXW'(1));
      w_m   = w_m << w_sh;
      w_exp = w_el - w_sh;
    end

    // Round to nearest, ties to even
    w_rup  = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_mant = {1'b0, w_m[XW-1:3]} + MTW'(w_rup);
    if (w_mant[MTW-1]) begin
      w_mant = w_mant >> 1;
      w_exp  = w_exp + EXW'(1);
    end

    if ((w_sl != w_ss) && (w_big == w_small)) begin
      w_fin_res = '0;
    end else if (w_exp >= EXW'(ExpOnes)) begin
      w_fin_res = {w_sl, ExpOnes, {MantissaWidth{1'b0}}};
      w_fin_ovf = 1'b1;
    end else begin
      w_eenc    = w_mant[MantissaWidth] ? w_exp[ExponentWidth-1:0] : '0;
      w_fin_res = {w_sl, w_eenc, w_mant[MantissaWidth-1:0]};
      w_fin_unf = ~w_mant[MantissaWidth];
    end
  end

  // Special-case selection in priority order
  logic [W-1:0] w_res;
  logic         w_unf, w_ovf, w_inv;

  always_comb begin
    w_res = w_fin_res;
    w_unf = w_fin_unf;
    w_ovf = w_fin_ovf;
    w_inv = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      w_res = {1'b1, ExpOnes, 1'b1, {(MantissaWidth-1){1'b0}}};
      w_unf = 1'b0; w_ovf = 1'b0; w_inv = 1'b1;
    end else if (w_a_inf) begin
      w_res = {w_sa, ExpOnes, {MantissaWidth{1'b0}}};
      w_unf = 1'b0; w_ovf = 1'b1;
    end else if (w_b_inf) begin
      w_res = {w_sb, ExpOnes, {MantissaWidth{1'b0}}};
      w_unf = 1'b0; w_ovf = 1'b1;
    end else if (w_a_zero && w_b_zero) begin
      w_res = {(w_sa & w_sb), {(W-1){1'b0}}};
      w_unf = 1'b0; w_ovf = 1'b0;
    end else if (w_a_zero) begin
      w_res = {w_sb, b[W-2:0]};
      w_unf = 1'b0; w_ovf = 1'b0;
    end else if (w_b_zero) begin
      w_res = a;
      w_unf = 1'b0; w_ovf = 1'b0;
    end
  end

  // Output register
  logic [W-1:0] r_out;
  logic         r_unf, r_ovf, r_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_unf <= 1'b0;
      r_ovf <= 1'b0;
      r_inv <= 1'b0;
    end else begin
      r_out <= w_res;
      r_unf <= w_unf;
      r_ovf <= w_ovf;
      r_inv <= w_inv;
    end
  end

  assign out                    = r_out;
  assign underflow_flag         = r_unf;
  assign overflow_flag          = r_ovf;
  assign invalid_operation_flag = r_inv;

endmodule

// File: tb/tb_floating_point_adder.sv
// Directed-vector bench for floating_point_adder (binary32 configuration).
module tb_floating_point_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        subtract;
  logic [31:0] out;
  logic        underflow_flag, overflow_flag, invalid_operation_flag;

  int checks;
  int failures;

  floating_point_adder #(.ExponentWidth(8), .MantissaWidth(23)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .a                      (a),
    .b                      (b),
    .subtract               (subtract),
    .out                    (out),
    .underflow_flag         (underflow_flag),
    .overflow_flag          (overflow_flag),
    .invalid_operation_flag (invalid_operation_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected packed as {out, underflow, overflow, invalid}
  task automatic check(input string tag, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got out=%08h flags(u,o,i)=%03b, want out=%08h flags=%03b",
               tag, act[34:3], act[2:0], exp[34:3], exp[2:0]);
    end
  endtask

  function automatic logic [34:0] obs();
    return {out, underflow_flag, overflow_flag, invalid_operation_flag};
  endfunction

  // Apply at the falling edge, sample 1 time unit after the next rising edge
  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vs, input logic [31:0] eo, input logic [2:0] ef);
    @(negedge clk);
    a = va; b = vb; subtract = vs;
    @(posedge clk);
    #1;
    check(tag, obs(), {eo, ef});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a = 32'h40400000; b = 32'h40800000; subtract = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), 35'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function
    run_vec("add_3_4",       32'h40400000, 32'h40800000, 1'b0, 32'h40E00000, 3'b000);
    run_vec("add_rne",       32'h410B3333, 32'h3E99999A, 1'b0, 32'h41100000, 3'b000);
    run_vec("add_big_small", 32'h469C4600, 32'h3DCCCCCD, 1'b0, 32'h469C4633, 3'b000);
    run_vec("add_small_big", 32'h38D1B717, 32'h3F6E147B, 1'b0, 32'h3F6E1B09, 3'b000);
    run_vec("sub_3_4",       32'h40400000, 32'h40800000, 1'b1, 32'hBF800000, 3'b000);
    run_vec("tie_even_down", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    run_vec("tie_even_up",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);

    // Infinities
    run_vec("inf_plus_3",    32'h7F800000, 32'h40400000, 1'b0, 32'h7F800000, 3'b010);
    run_vec("ninf_ninf",     32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b010);
    run_vec("ninf_pinf",     32'hFF800000, 32'h7F800000, 1'b0, 32'hFFC00000, 3'b001);
    run_vec("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'hFFC00000, 3'b001);

    // NaN and zeros
    run_vec("qnan_plus_0",   32'hFFC00000, 32'h00000000, 1'b0, 32'hFFC00000, 3'b001);
    run_vec("snan_plus_0",   32'hFFA00000, 32'h00000000, 1'b0, 32'hFFC00000, 3'b001);
    run_vec("zero_plus_3",   32'h00000000, 32'h40400000, 1'b0, 32'h40400000, 3'b000);
    run_vec("zero_minus_3",  32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 3'b000);
    run_vec("x_plus_zero",   32'h42F00000, 32'h00000000, 1'b0, 32'h42F00000, 3'b000);
    run_vec("pz_plus_nz",    32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
    run_vec("nz_plus_nz",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);

    // Boundaries
    run_vec("max_plus_max",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
    run_vec("min_minus_sub", 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b100);
    run_vec("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);

    // Latency: output holds the previous result until the next rising edge
    @(negedge clk);
    a = 32'h40400000; b = 32'h40800000; subtract = 1'b0;
    #1;
    check("latency_hold", obs(), {32'h00000000, 3'b000});
    @(posedge clk);
    #1;
    check("latency_update", obs(), {32'h40E00000, 3'b000});

    // Asynchronous reset between edges clears immediately and holds
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), 35'h0);
    @(posedge clk);
    #1;
    check("reset_hold", obs(), 35'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset", obs(), {32'h40E00000, 3'b000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the run regardless of anything above
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/floating_point_adder.md
# floating_point_adder

Parametrizable IEEE-754 binary floating-point adder/subtractor with round-to-nearest-even and exception flags. It computes a + b, or a − b when subtract is set, and registers the result and flags. It serves as the add stage of the parametrizable floating-point datapath, alongside the multiplier.

## Interface
- ExponentWidth, 8, exponent field width; bias = 2^(ExponentWidth−1) − 1
- MantissaWidth, 23, stored fraction width; word width W = ExponentWidth + MantissaWidth + 1
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous and active-low
- a  input  W  operand A as {sign, exponent, fraction}
- b  input  W  operand B
- subtract  input  1  when 1, invert b's sign before adding
- out  output  W  registered result
- underflow_flag  output  1  registered; result is tiny
- overflow_flag  output  1  registered; result is infinity
- invalid_operation_flag  output  1  registered; result is NaN

## Operation
- Effective sign of b is b.sign XOR subtract.
- Classify each operand: zero (exp=0, frac=0), subnormal (exp=0, frac≠0), normal, infinity (exp all ones, frac=0), NaN (exp all ones, frac≠0).
- Special cases, in priority order:
  - Either operand is NaN (quiet or signalling) → canonical QNaN {1, all ones, 1, 0…0}, e.g. 0xFFC00000; invalid=1.
  - Infinities of opposite effective sign → canonical QNaN; invalid=1.
  - Either operand is infinity → that infinity with its effective sign; overflow=1.
  - Both operands zero → sign is the AND of the effective signs, so +0 + −0 = +0 and −0 + −0 = −0.
  - One operand zero → the other operand unchanged, including its effective sign.
- Finite path:
  - Form significands with a hidden bit of 1 for normals and 0 for subnormals. Subnormals use exponent 1.
  - Order the operands by magnitude and shift the smaller right by the exponent difference.
  - Keep guard, round and sticky bits. A shift of MantissaWidth+3 or more collapses the operand into sticky.
  - Same effective sign: add magnitudes; a carry-out normalizes right by 1 and increments the exponent.
  - Opposite sign: subtract smaller from larger, then normalize left by the leading-zero count. The left shift is limited so the exponent does not fall below 1; the result then encodes as a subnormal.
  - Result sign is the sign of the larger-magnitude operand.
- Exact zero difference → +0, no flags.
- Rounding is round-to-nearest, ties-to-even. A rounding carry renormalizes and increments the exponent.
- Exponent reaching all ones after rounding → infinity of the result sign; overflow=1.
- Nonzero result with biased exponent 0 after rounding → subnormal encoding; underflow=1.
- At most one flag is set per result. All flags are 0 for normal results and for zero results.

## Timing
- Fully combinational compute. out and the three flags are registered on the rising clk edge.
- Latency: 1 cycle. Inputs sampled at edge N appear at the outputs after edge N.
- Throughput: one operation per cycle; no handshake, no stall.
- rst_n low asynchronously forces out=0 and all flags=0 and holds them there.
- The first operation after rst_n rises is the one sampled at the next rising edge.
- Reset asserted mid-stream discards the in-flight result.

## Test plan
- 0x40400000 + 0x40800000, subtract=0 → 0x40E00000 (7.0), flags 000. Then 0x410B3333 + 0x3E99999A → 0x41100000 (exercises RNE).
- 0x469C4600 + 0x3DCCCCCD → 0x469C4633. Then 0x38D1B717 + 0x3F6E147B → 0x3F6E1B09. Flags 000 for both.
- Infinities:
  - 0x7F800000 + 0x40400000 → 0x7F800000, overflow=1.
  - 0xFF800000 + 0xFF800000 → 0xFF800000, overflow=1.
  - 0xFF800000 + 0x7F800000 → 0xFFC00000, invalid=1.
  - 0x7F800000 − 0x7F800000 → 0xFFC00000, invalid=1.
- NaN and zeros:
  - 0xFFC00000 + 0 → 0xFFC00000, invalid=1.
  - 0xFFA00000 + 0 → 0xFFC00000, invalid=1.
  - 0 + 0x40400000 → 0x40400000.
  - 0x42F00000 + 0 → 0x42F00000.
  - 0x00000000 + 0x80000000 → 0x00000000.
- Boundaries:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1.
  - 0x00800000 − 0x00000001 → 0x007FFFFF, underflow=1.
  - 0x3F800000 − 0x3F800000 → 0x00000000.
- Timing:
  - Result appears exactly one edge after the inputs are applied.
  - Back-to-back operations stream at one per cycle.
  - rst_n pulsed low between edges clears out and the flags immediately.
